// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding decode.
// Holds the PC and issues one word address per cycle to a synchronous-read
// memory. Returned words are queued with their PCs in a prefetch FIFO so that
// memory latency is decoupled from decode stalls. flush with branch redirects
// the fetch; flush without branch halts fetch until reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             decode cannot accept; hold FIFO head
//   flush             drop queued and in-flight fetches
//   branch            with flush: redirect to branch_tgt (else halt)
//   branch_tgt[15:0]  redirect address
//   fetch_addr[15:0]  memory read address (PC register)
//   mem_data[15:0]    memory read data, one cycle after fetch_addr
//   instr_out[15:0]   instruction at FIFO head (0 when empty)
//   pc_out[15:0]      address of instr_out (0 when empty)
//   bubble_out        1 when no valid instruction is presented
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch,
  input  logic [15:0] branch_tgt,
  output logic [15:0] fetch_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        bubble_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    RUN,
    HALTED
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [15:0]   pc_q;
  logic          inflight_q;
  logic [15:0]   inflight_pc_q;
  logic [15:0]   fifo_pc    [DEPTH];
  logic [15:0]   fifo_instr [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Reserve a slot for the in-flight word; a same-cycle pop earns no credit,
  // which keeps a push from ever landing on a full FIFO.
  assign occupancy = count_q + CW'(inflight_q);
  assign issue     = (mode_q == RUN) && !flush && (occupancy < DEPTH_C);
  assign push      = inflight_q && !flush;
  assign pop       = (count_q != '0) && !stall;

  // Mode FSM: halt is entered by flush without branch; only rst leaves it.
  always_ff @(posedge clk) begin
    if (rst) mode_q <= RUN;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (flush && !branch) mode_d = HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else if (flush) begin
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      if (branch && mode_q == RUN) pc_q <= branch_tgt;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 16'd1;
      end
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc[tail_q]    <= inflight_pc_q;
      fifo_instr[tail_q] <= mem_data;
    end
  end

  assign fetch_addr = pc_q;

  always_comb begin
    bubble_out = (count_q == '0);
    instr_out  = '0;
    pc_out     = '0;
    if (!bubble_out) begin
      instr_out = fifo_instr[head_q];
      pc_out    = fifo_pc[head_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. Two instances: one with
// RESET_PC=0 for the main scenarios, one with RESET_PC=FFFE for PC wrap.
// Memory model: word k = 16'hA000 + k, read synchronously.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, branch;
  logic [15:0] branch_tgt, fetch_addr, mem_data, instr_out, pc_out;
  logic        bubble_out;

  logic        rst1;
  logic [15:0] fetch_addr1, mem_data1, instr_out1, pc_out1;
  logic        bubble_out1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch(branch),
    .branch_tgt(branch_tgt), .fetch_addr(fetch_addr), .mem_data(mem_data),
    .instr_out(instr_out), .pc_out(pc_out), .bubble_out(bubble_out)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst1), .stall(1'b0), .flush(1'b0), .branch(1'b0),
    .branch_tgt(16'h0000), .fetch_addr(fetch_addr1), .mem_data(mem_data1),
    .instr_out(instr_out1), .pc_out(pc_out1), .bubble_out(bubble_out1)
  );

  always @(posedge clk) begin
    mem_data  <= 16'hA000 + fetch_addr;
    mem_data1 <= 16'hA000 + fetch_addr1;
  end

  function automatic logic [15:0] word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0; branch_tgt = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".fetch_addr"}, fetch_addr, 16'h0000);
    check({tag, ".bubble"},     {15'd0, bubble_out}, 16'd1);
    check({tag, ".instr"},      instr_out, 16'h0000);
    check({tag, ".pc"},         pc_out, 16'h0000);
  endtask

  task automatic check_out(input string tag, input logic [15:0] pc);
    check({tag, ".bubble"}, {15'd0, bubble_out}, 16'd0);
    check({tag, ".pc"},     pc_out, pc);
    check({tag, ".instr"},  instr_out, word(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0;
    branch_tgt = '0;

    // Reset, stream, stall for cycles 3..8, ignored branch
    do_reset();
    check_reset_state("rst0");
    tick();
    check("c1.bubble", {15'd0, bubble_out}, 16'd1);
    tick();
    check_out("c2", 16'd0);
    check("c2.fetch_addr", fetch_addr, 16'd2);
    tick();
    check_out("c3", 16'd1);
    stall = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      tick();
      check_out("stall_hold", 16'd1);
      check("stall_fetch", fetch_addr, (i < 5) ? 16'(i) : 16'd5);
    end
    tick();
    stall = 1'b0;
    check_out("c9", 16'd1);
    for (int k = 2; k <= 9; k++) begin
      tick();
      check_out("drain", 16'(k));
    end
    branch = 1'b1; branch_tgt = 16'h1234;
    tick();
    branch = 1'b0;
    check_out("nobr0", 16'd10);
    tick();
    check_out("nobr1", 16'd11);

    // Flush+branch with 3 entries queued
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick(); tick();
    check_out("pre_flush", 16'd1);
    flush = 1'b1; branch = 1'b1; branch_tgt = 16'h0040; stall = 1'b0;
    tick();
    flush = 1'b0; branch = 1'b0;
    check("fl1.bubble", {15'd0, bubble_out}, 16'd1);
    check("fl1.fetch_addr", fetch_addr, 16'h0040);
    check("fl1.pc", pc_out, 16'h0000);
    check("fl1.instr", instr_out, 16'h0000);
    tick();
    check("fl2.bubble", {15'd0, bubble_out}, 16'd1);
    // Target issues the cycle after flush, so it reaches the head two later
    tick();
    check_out("fl3", 16'h0040);
    for (int k = 16'h41; k <= 16'h44; k++) begin
      tick();
      check_out("post_flush", 16'(k));
    end

    // Halt: flush without branch
    flush = 1'b1; branch = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("halt.bubble", {15'd0, bubble_out}, 16'd1);
      check("halt.fetch_addr", fetch_addr, 16'h0046);
      tick();
    end
    do_reset();
    check_reset_state("rst_halt");
    tick(); tick();
    check_out("restart", 16'd0);

    // Flush+stall with a full FIFO
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick(); tick(); tick(); tick();
    check_out("full", 16'd1);
    check("full.fetch_addr", fetch_addr, 16'd5);
    flush = 1'b1; branch = 1'b1; branch_tgt = 16'h0080;
    tick();
    flush = 1'b0; branch = 1'b0;
    check("fs1.bubble", {15'd0, bubble_out}, 16'd1);
    check("fs1.fetch_addr", fetch_addr, 16'h0080);
    tick();
    tick();
    check_out("fs3", 16'h0080);
    tick();
    check_out("fs4_hold", 16'h0080);
    stall = 1'b0;
    tick();
    check_out("fs5", 16'h0081);
    tick();
    check_out("fs6", 16'h0082);

    // Reset mid-operation with a full FIFO
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check_reset_state("rst_full");
    rst = 1'b0; stall = 1'b0;

    // PC wrap on the RESET_PC=FFFE instance
    tick(); tick();
    rst1 = 1'b0;
    check("wrap.fetch_addr", fetch_addr1, 16'hFFFE);
    check("wrap.bubble0", {15'd0, bubble_out1}, 16'd1);
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_pc;
      exp_pc = 16'hFFFE + 16'(k);
      check("wrap.bubble", {15'd0, bubble_out1}, 16'd0);
      check("wrap.pc", pc_out1, exp_pc);
      check("wrap.instr", instr_out1, word(exp_pc));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
